// File: rtl/decode_pkg.sv
// Shared types for the instruction decode stage.
// Opcode map, type codes and the decoded bundle.
package decode_pkg;

  localparam int unsigned IMM_W = 64;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_U    = 3'd1,
    T_J    = 3'd2,
    T_B    = 3'd3,
    T_I    = 3'd4,
    T_S    = 3'd5,
    T_R    = 3'd6
  } instr_type_e;

  // imm is held at full RV64 width, already
  // sign-extended; the stage trims it to XLEN.
  typedef struct packed {
    logic [6:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [IMM_W-1:0] imm;
    instr_type_e      itype;
    logic             illegal;
  } decoded_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational RISC-V field extraction.
// Unused fields stay 0; illegal words keep only op.
module instr_field_decoder
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] op;
  logic       rv64;
  logic       is_u;
  logic       is_j;
  logic       is_b;
  logic       is_i;
  logic       is_s;
  logic       is_r;

  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;
  logic [63:0] imm_u;
  logic [63:0] imm_j;

  assign op   = instr[6:0];
  assign rv64 = (XLEN == 64);

  assign is_u = (op == OP_LUI) || (op == OP_AUIPC);
  assign is_j = (op == OP_JAL);
  assign is_b = (op == OP_BRANCH);
  assign is_i = (op == OP_JALR)
             || (op == OP_LOAD)
             || (op == OP_IMM)
             || (op == OP_FENCE)
             || (op == OP_SYSTEM)
             || (rv64 && op == OP_IMM32);
  assign is_s = (op == OP_STORE);
  assign is_r = (op == OP_REG)
             || (rv64 && op == OP_REG32);

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31],
                  instr[7], instr[30:25],
                  instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12],
                  12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  // Route only the fields each format defines.
  always_comb begin
    dec    = '0;
    dec.op = op;
    unique case (1'b1)
      is_u: begin
        dec.itype = T_U;
        dec.rd    = instr[11:7];
        dec.imm   = imm_u;
      end
      is_j: begin
        dec.itype = T_J;
        dec.rd    = instr[11:7];
        dec.imm   = imm_j;
      end
      is_b: begin
        dec.itype  = T_B;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.imm    = imm_b;
      end
      is_i: begin
        dec.itype  = T_I;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.funct3 = instr[14:12];
        dec.imm    = imm_i;
      end
      is_s: begin
        dec.itype  = T_S;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.imm    = imm_s;
      end
      is_r: begin
        dec.itype  = T_R;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decoder feeding a small FIFO.
// in_ready depends on the registered count only.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  decoded_t        dec;
  decoded_t        head;
  decoded_t        mem [DEPTH];
  logic [XLEN-1:0] pcm [DEPTH];
  logic [XLEN-1:0] head_pc;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  instr_field_decoder #(
    .XLEN (XLEN)
  ) u_dec (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Entry storage; contents matter only below count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= dec;
      pcm[wptr] <= in_pc;
    end
  end

  // Pointers and occupancy; flush wins over traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head    = mem[rptr];
  assign head_pc = pcm[rptr];

  // Zero every data output while nothing is held.
  always_comb begin
    out_pc      = '0;
    out_op      = '0;
    out_rd      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_funct3  = '0;
    out_funct7  = '0;
    out_imm     = '0;
    out_type    = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = head_pc;
      out_op      = head.op;
      out_rd      = head.rd;
      out_rs1     = head.rs1;
      out_rs2     = head.rs2;
      out_funct3  = head.funct3;
      out_funct7  = head.funct7;
      out_imm     = XLEN'(head.imm);
      out_type    = 3'(head.itype);
      out_illegal = head.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage.
// Runs an XLEN=32 and an XLEN=64 build side by side.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, ov32, ill32;
  logic [31:0] pc32, imm32;
  logic [6:0]  op32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32, ty32;

  logic        rdy64, ov64, ill64;
  logic [63:0] pc64, imm64;
  logic [6:0]  op64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64, ty64;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(ov32), .out_ready(out_ready),
    .out_pc(pc32), .out_op(op32),
    .out_rd(rd32), .out_rs1(rs1_32),
    .out_rs2(rs2_32), .out_funct3(f3_32),
    .out_funct7(f7_32), .out_imm(imm32),
    .out_type(ty32), .out_illegal(ill32)
  );

  decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov64), .out_ready(out_ready),
    .out_pc(pc64), .out_op(op64),
    .out_rd(rd64), .out_rs1(rs1_64),
    .out_rs2(rs2_64), .out_funct3(f3_64),
    .out_funct7(f7_64), .out_imm(imm64),
    .out_type(ty64), .out_illegal(ill64)
  );

  typedef struct {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  t32, t64;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } tv_t;

  tv_t  tv [11];
  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur = 0;
  bit   accepted;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int idx,
                              input int w,
                              input logic [63:0] pc);
    exp_t e;
    tv_t  t;
    logic [2:0] ty;
    t  = tv[idx];
    ty = (w == 32) ? t.t32 : t.t64;
    e  = '{default: '0};
    e.pc  = (w == 32) ? {32'b0, pc[31:0]} : pc;
    e.op  = t.instr[6:0];
    e.ty  = ty;
    e.ill = (ty == 3'd0);
    if (ty != 3'd0) begin
      e.rd  = t.rd;
      e.rs1 = t.rs1;
      e.rs2 = t.rs2;
      e.f3  = t.f3;
      e.f7  = t.f7;
      e.imm = (w == 32) ? {32'b0, t.imm[31:0]}
                        : t.imm;
    end
    return e;
  endfunction

  function automatic exp_t got32();
    exp_t g;
    g.pc = {32'b0, pc32}; g.op = op32;
    g.rd = rd32; g.rs1 = rs1_32; g.rs2 = rs2_32;
    g.f3 = f3_32; g.f7 = f7_32;
    g.imm = {32'b0, imm32};
    g.ty = ty32; g.ill = ill32;
    return g;
  endfunction

  function automatic exp_t got64();
    exp_t g;
    g.pc = pc64; g.op = op64;
    g.rd = rd64; g.rs1 = rs1_64; g.rs2 = rs2_64;
    g.f3 = f3_64; g.f7 = f7_64;
    g.imm = imm64;
    g.ty = ty64; g.ill = ill64;
    return g;
  endfunction

  task automatic cmp(input string s,
                     input exp_t g, input exp_t e);
    chk({s, "_pc"},  g.pc,  e.pc);
    chk({s, "_op"},  64'(g.op),  64'(e.op));
    chk({s, "_rd"},  64'(g.rd),  64'(e.rd));
    chk({s, "_rs1"}, 64'(g.rs1), 64'(e.rs1));
    chk({s, "_rs2"}, 64'(g.rs2), 64'(e.rs2));
    chk({s, "_f3"},  64'(g.f3),  64'(e.f3));
    chk({s, "_f7"},  64'(g.f7),  64'(e.f7));
    chk({s, "_imm"}, g.imm, e.imm);
    chk({s, "_type"}, 64'(g.ty), 64'(e.ty));
    chk({s, "_ill"}, 64'(g.ill), 64'(e.ill));
  endtask

  task automatic zero_chk(input string s);
    exp_t z;
    z = '{default: '0};
    cmp({s, "32"}, got32(), z);
    cmp({s, "64"}, got64(), z);
  endtask

  // Called at a negedge with inputs already set.
  task automatic tick();
    exp_t e;
    if (ov32 && out_ready && !flush) begin
      if (q32.size() == 0) chk("sb32_empty", 1, 0);
      else begin
        e = q32.pop_front();
        cmp("out32", got32(), e);
      end
    end
    if (ov64 && out_ready && !flush) begin
      if (q64.size() == 0) chk("sb64_empty", 1, 0);
      else begin
        e = q64.pop_front();
        cmp("out64", got64(), e);
      end
    end
    if (!ov32) chk("idle32",
      64'(|{pc32, op32, rd32, rs1_32, rs2_32,
            f3_32, f7_32, imm32, ty32, ill32}), 0);
    accepted = in_valid && rdy32 && !flush;
    if (accepted) begin
      q32.push_back(mk(cur, 32, in_pc));
      q64.push_back(mk(cur, 64, in_pc));
    end
    if (flush) begin
      q32.delete();
      q64.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int i,
                       input logic [63:0] base);
    cur      = i;
    in_valid = 1'b1;
    in_instr = tv[i].instr;
    in_pc    = base + 64'(4 * i);
  endtask

  initial begin
    exp_t saved;
    int   k;

    tv[0]  = '{32'h123450B7, 3'd1, 3'd1, 5'd1, 5'd0,
               5'd0, 3'd0, 7'h00, 64'h12345000};
    tv[1]  = '{32'hFE000EE3, 3'd3, 3'd3, 5'd0, 5'd0,
               5'd0, 3'd0, 7'h00,
               64'hFFFF_FFFF_FFFF_FFFC};
    tv[2]  = '{32'hFFF30293, 3'd4, 3'd4, 5'd5, 5'd6,
               5'd0, 3'd0, 7'h00,
               64'hFFFF_FFFF_FFFF_FFFF};
    tv[3]  = '{32'h00712423, 3'd5, 3'd5, 5'd0, 5'd2,
               5'd7, 3'd2, 7'h00, 64'h8};
    tv[4]  = '{32'h402081B3, 3'd6, 3'd6, 5'd3, 5'd1,
               5'd2, 3'd0, 7'h20, 64'h0};
    tv[5]  = '{32'hFFDFF06F, 3'd2, 3'd2, 5'd0, 5'd0,
               5'd0, 3'd0, 7'h00,
               64'hFFFF_FFFF_FFFF_FFFC};
    tv[6]  = '{32'h0010809B, 3'd0, 3'd4, 5'd1, 5'd1,
               5'd0, 3'd0, 7'h00, 64'h1};
    tv[7]  = '{32'h00000000, 3'd0, 3'd0, 5'd0, 5'd0,
               5'd0, 3'd0, 7'h00, 64'h0};
    tv[8]  = '{32'h80000517, 3'd1, 3'd1, 5'd10, 5'd0,
               5'd0, 3'd0, 7'h00,
               64'hFFFF_FFFF_8000_0000};
    tv[9]  = '{32'h003100BB, 3'd0, 3'd6, 5'd1, 5'd2,
               5'd3, 3'd0, 7'h00, 64'h0};
    tv[10] = '{32'h00000001, 3'd0, 3'd0, 5'd0, 5'd0,
               5'd0, 3'd0, 7'h00, 64'h0};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;

    #12;
    chk("rst_ready", 64'(rdy32), 1);
    chk("rst_valid", 64'(ov32), 0);
    chk("rst_valid64", 64'(ov64), 0);
    zero_chk("rst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_ready", 64'(rdy32), 1);
    chk("idle_valid", 64'(ov32), 0);

    // Streaming at full rate through both builds.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(i, 64'h100);
      tick();
      chk("stream_acc", 64'(accepted), 1);
      if (i == 0) chk("lat_valid", 64'(ov32), 1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_left", 64'(q32.size() + q64.size()), 0);

    // Backpressure: third push must be held.
    out_ready = 1'b0;
    drive(0, 64'h200);
    tick();
    drive(1, 64'h200);
    tick();
    chk("bp_ready", 64'(rdy32), 0);
    chk("bp_ready64", 64'(rdy64), 0);
    drive(2, 64'h200);
    saved = got32();
    tick();
    chk("bp_held", 64'(accepted), 0);
    tick();
    chk("bp_held2", 64'(accepted), 0);
    chk("bp_stable_pc", 64'(pc32), saved.pc);
    chk("bp_stable_op", 64'(op32), 64'(saved.op));
    out_ready = 1'b1;
    k = 0;
    while (k < 10 && (q32.size() != 0 || in_valid)) begin
      tick();
      if (accepted) in_valid = 1'b0;
      k++;
    end
    chk("bp_drained",
        64'(q32.size() + q64.size() + int'(in_valid)), 0);
    tick();
    chk("bp_empty", 64'(ov32), 0);

    // Flush with two held and one arriving.
    out_ready = 1'b0;
    drive(3, 64'h300);
    tick();
    drive(4, 64'h300);
    tick();
    chk("fl_full", 64'(ov32 && !rdy32), 1);
    drive(5, 64'h300);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(ov32), 0);
    chk("fl_valid64", 64'(ov64), 0);
    chk("fl_ready", 64'(rdy32), 1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("fl_dropped", 64'(ov32 || ov64), 0);

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    drive(8, 64'h400);
    tick();
    drive(2, 64'h400);
    tick();
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(ov32), 0);
    chk("ar_valid64", 64'(ov64), 0);
    chk("ar_ready", 64'(rdy32), 1);
    zero_chk("ar");
    q32.delete();
    q64.delete();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ar_after", 64'(ov32), 0);

    chk("sb_final", 64'(q32.size() + q64.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
